// File: rtl/rv_pkg.sv
// Shared front-end types: fetch FSM states and the IF/ID pipeline register
// payload, which the decode-stage register reuses.
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: one word request, one response.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats load beats stall; an empty slot shows a NOP.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      q_q <= '{valid: 1'b0, inst: NOP, pc: 32'h0, pc_plus4: 32'h0};
    else if (flush_i)
      q_q <= '{valid: 1'b0, inst: NOP, pc: q_q.pc, pc_plus4: q_q.pc_plus4};
    else if (load_i)
      q_q <= d_i;
    else if (!stall_i)
      q_q <= '{valid: 1'b0, inst: NOP, pc: q_q.pc, pc_plus4: q_q.pc_plus4};
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one request in flight, parks a response
// in a hold buffer while ID is stalled, and squashes wrong-path data on redirect.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master imem,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall_id,
  output logic         id_valid,
  output logic [31:0]  id_inst,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         drop_q, drop_d;
  logic         req;
  logic         load;
  logic [31:0]  load_inst;
  if_id_t       load_data;
  if_id_t       ifid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      hold_q   <= NOP_INST;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    hold_d    = hold_q;
    drop_d    = drop_q;
    req       = 1'b0;
    load      = 1'b0;
    load_inst = imem.imem_rdata;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          // An accepted request that races a redirect is still owed a response;
          // mark it so that response is thrown away.
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          drop_d   = redirect_valid;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
          if (!drop_q && !redirect_valid) begin
            if (!id_valid || !stall_id) begin
              load = 1'b1;
            end else begin
              hold_d  = imem.imem_rdata;
              state_d = S_FULL;
            end
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (!stall_id) begin
          load      = 1'b1;
          load_inst = hold_q;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) pc_d = word_align(redirect_pc);
  end

  assign load_data = '{valid: 1'b1, inst: load_inst, pc: req_pc_q, pc_plus4: req_pc_q + 32'd4};

  if_id_reg #(.NOP(NOP_INST)) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (redirect_valid),
    .stall_i (stall_id),
    .load_i  (load),
    .d_i     (load_data),
    .q_o     (ifid)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = word_align(pc_q);
  assign id_valid       = ifid.valid;
  assign id_inst        = ifid.inst;
  assign id_pc          = ifid.pc;
  assign id_pc_plus4    = ifid.pc_plus4;

endmodule
